// File: rtl/mb_block_dispatcher.sv
// mb_block_dispatcher: walks one plane in raster order and issues block (x,y) to NUM_ENG engines
// using round-robin arbitration, tracking one outstanding block per engine.
module mb_block_dispatcher #(
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  parameter int BLK_W   = 4,
  parameter int BLK_H   = 4,
  parameter int NUM_ENG = 2,
  parameter int COORD_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [NUM_ENG-1:0] i_eng_req,
  input  logic [NUM_ENG-1:0] i_eng_done,
  output logic [NUM_ENG-1:0] o_eng_grant,
  output logic [COORD_W-1:0] o_blk_x,
  output logic [COORD_W-1:0] o_blk_y,
  output logic [CNT_W-1:0]   o_issued_cnt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);
  localparam int PW = NUM_ENG > 1 ? $clog2(NUM_ENG) : 1;

  if (FRAME_W % BLK_W != 0) begin : g_bad_w
    $error("FRAME_W must be a multiple of BLK_W");
  end
  if (FRAME_H % BLK_H != 0) begin : g_bad_h
    $error("FRAME_H must be a multiple of BLK_H");
  end
  if (NUM_ENG < 1) begin : g_bad_n
    $error("NUM_ENG must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [COORD_W-1:0] r_x, r_y, r_bx, r_by;
  logic [NUM_ENG-1:0] r_out, r_grant;
  logic [PW-1:0]      r_rr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [NUM_ENG-1:0] w_elig, w_onehot, w_out_nxt, w_out_left;
  logic [PW-1:0]      w_hi, w_lo, w_win, w_rr_nxt;
  logic               w_hi_ok, w_lo_ok, w_go, w_start, w_last_x, w_last_blk;

  // Winner is the lowest eligible engine at or above rr_ptr, else the lowest eligible overall.
  always_comb begin
    w_elig  = i_eng_req & ~r_out;
    w_hi_ok = 1'b0;
    w_lo_ok = 1'b0;
    w_hi    = '0;
    w_lo    = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_ok = 1'b1;
        w_lo    = PW'(i);
        if (PW'(i) >= r_rr) begin
          w_hi_ok = 1'b1;
          w_hi    = PW'(i);
        end
      end
    end
  end

  assign w_win      = w_hi_ok ? w_hi : w_lo;
  assign w_rr_nxt   = (w_win == PW'(NUM_ENG - 1)) ? '0 : w_win + PW'(1);
  assign w_onehot   = NUM_ENG'(1) << w_win;
  assign w_go       = (r_state == RUN) && w_lo_ok;
  assign w_start    = i_start && (r_state == IDLE || r_state == DONE);
  assign w_last_x   = r_x == COORD_W'(FRAME_W - BLK_W);
  assign w_last_blk = w_last_x && r_y == COORD_W'(FRAME_H - BLK_H);
  assign w_out_left = r_out & ~i_eng_done;
  assign w_out_nxt  = w_out_left | (w_go ? w_onehot : '0);

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) w_state_nxt = RUN;
    else if (r_state == RUN && w_go && w_last_blk) w_state_nxt = DRAIN;
    else if (r_state == DRAIN && w_out_left == '0) w_state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_out   <= '0;
      r_grant <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_grant <= w_go ? w_onehot : '0;
      if (w_start) begin
        r_x   <= '0;
        r_y   <= '0;
        r_cnt <= '0;
        r_rr  <= '0;
        r_err <= 1'b0;
      end else begin
        r_err <= r_err | (|(i_eng_done & ~r_out));
        if (w_go) begin
          r_x   <= w_last_x ? '0 : r_x + COORD_W'(BLK_W);
          r_y   <= w_last_x ? r_y + COORD_W'(BLK_H) : r_y;
          r_bx  <= r_x;
          r_by  <= r_y;
          r_cnt <= r_cnt + CNT_W'(1);
          r_rr  <= w_rr_nxt;
        end
      end
    end
  end

  assign o_eng_grant  = r_grant;
  assign o_blk_x      = r_bx;
  assign o_blk_y      = r_by;
  assign o_issued_cnt = r_cnt;
  assign o_busy       = r_state == RUN || r_state == DRAIN;
  assign o_done       = r_state == DONE;
  assign o_err        = r_err;
endmodule
